// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank with byte strobes and independent AW/W/AR paths.
// Optional AXIL_SLV_ERR_EN: report SLVERR on out-of-range accesses.
`timescale 1ns/1ps
module axil_reg_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int LED_W    = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [LED_W-1:0]  led
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int HI_S   = IDX_W + OFF_W;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [IDX_W-1:0] f_idx(
    input logic [ADDR_W-1:0] a
  );
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic f_oor(
    input logic [ADDR_W-1:0] a
  );
    return (a >> HI_S) != '0;
  endfunction

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              r_aw_held;
  logic [IDX_W-1:0]  r_aw_idx;
  logic              r_aw_oor;
  logic              r_w_held;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;
  wstate_t           r_wst;
  logic              r_bvalid;

  rstate_t           r_rst;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;
  logic [IDX_W-1:0]  w_c_idx;
  logic              w_c_oor;
  logic [DATA_W-1:0] w_c_data;
  logic [STRB_W-1:0] w_c_strb;
  logic [IDX_W-1:0]  w_r_idx;
  logic              w_r_oor;

  assign AWREADY = !r_aw_held && (r_wst == W_IDLE);
  assign WREADY  = !r_w_held && (r_wst == W_IDLE);
  assign ARREADY = (r_rst == R_IDLE);

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  // Held values win; otherwise the beat handshaking this cycle is used
  assign w_c_idx  = r_aw_held ? r_aw_idx : f_idx(AWADDR);
  assign w_c_oor  = r_aw_held ? r_aw_oor : f_oor(AWADDR);
  assign w_c_data = r_w_held ? r_w_data : WDATA;
  assign w_c_strb = r_w_held ? r_w_strb : WSTRB;

  assign w_commit = (r_wst == W_IDLE)
                 && (r_aw_held || w_aw_hs)
                 && (r_w_held || w_w_hs);

  assign w_r_idx = f_idx(ARADDR);
  assign w_r_oor = f_oor(ARADDR);

  assign BVALID = r_bvalid;
  assign RVALID = r_rvalid;
  assign RDATA  = r_rdata;
  assign led    = r_regs[0][LED_W-1:0];

  // Latch AW and W beats until both are present
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_oor  <= 1'b0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= f_idx(AWADDR);
        r_aw_oor  <= f_oor(AWADDR);
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= WDATA;
        r_w_strb <= WSTRB;
      end
    end
  end

  // Register bank: byte-strobed update on commit
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_commit && !w_c_oor) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_c_strb[b])
          r_regs[w_c_idx][8*b +: 8] <= w_c_data[8*b +: 8];
    end
  end

`ifdef AXIL_SLV_ERR_EN
  logic [1:0] r_bresp;
  logic [1:0] r_rresp;
  assign BRESP = r_bresp;
  assign RRESP = r_rresp;

  // Response codes for the error-reporting build
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_bresp <= 2'b00;
      r_rresp <= 2'b00;
    end else begin
      if (w_commit)
        r_bresp <= w_c_oor ? 2'b10 : 2'b00;
      if (w_ar_hs)
        r_rresp <= w_r_oor ? 2'b10 : 2'b00;
    end
  end
`else
  assign BRESP = 2'b00;
  assign RRESP = 2'b00;
`endif

  // Write response FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wst    <= W_IDLE;
      r_bvalid <= 1'b0;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          if (w_commit) begin
            r_wst    <= W_RESP;
            r_bvalid <= 1'b1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_wst    <= W_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: begin
          r_wst    <= W_IDLE;
          r_bvalid <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: pre-write value is captured on a same-edge commit
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rst    <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rst    <= R_DATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_r_oor ? '0 : r_regs[w_r_idx];
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_rst    <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_rst    <= R_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (default parameters).
// Expected error codes follow AXIL_SLV_ERR_EN.
`timescale 1ns/1ps
module tb_axil_reg_slave;

`ifdef AXIL_SLV_ERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [15:0] led;

  axil_reg_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .RVALID(RVALID), .RREADY(RREADY),
    .led(led)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    output logic [1:0] resp);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1;
    BREADY = 1'b1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("wr_ready_timeout", 0, 1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_bvalid_lat1", BVALID, 1);
    resp = BRESP;
    tick();
    chk("wr_bvalid_drop", BVALID, 0);
    BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d,
                    output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1'b1;
    RREADY = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("rd_ready_timeout", 0, 1);
    tick();
    ARVALID = 1'b0;
    chk("rd_rvalid_lat1", RVALID, 1);
    d = RDATA;
    resp = RRESP;
    tick();
    chk("rd_rvalid_drop", RVALID, 0);
    RREADY = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
    vt[1]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1'b1, 32'h00, 32'h0000A5A5, 4'hF, 32'h0, 2'b00};
    vt[3]  = '{1'b1, 32'h00, 32'hFFFF1234, 4'h2, 32'h0, 2'b00};
    vt[4]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h000012A5, 2'b00};
    vt[5]  = '{1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 2'b00};
    vt[6]  = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b00};
    vt[7]  = '{1'b1, 32'h14, 32'hCAFEF00D, 4'hC, 32'h0, 2'b00};
    vt[8]  = '{1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFE0000, 2'b00};
    vt[9]  = '{1'b1, 32'h1F, 32'h01020304, 4'hF, 32'h0, 2'b00};
    vt[10] = '{1'b0, 32'h1C, 32'h0, 4'h0, 32'h01020304, 2'b00};
    vt[11] = '{1'b1, 32'h40, 32'h00000099, 4'hF, 32'h0, ERR};
    vt[12] = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h0, ERR};
    vt[13] = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h000012A5, 2'b00};
    vt[14] = '{1'b0, 32'h06, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};

    // Reset state
    repeat (2) tick();
    ARESET = 1'b0;
    tick();
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_led", led, 0);

    // Table-driven writes and reads
    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) begin
        wr(vt[i].addr, vt[i].data, vt[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), r, vt[i].resp);
      end else begin
        rd(vt[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
        chk($sformatf("vec%0d_rresp", i), r, vt[i].resp);
      end
    end
    chk("led_after_strobe", led, 16'h12A5);

    // W three cycles ahead of AW, then BREADY stalled
    WDATA = 32'h11; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b0;
    tick();
    WVALID = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("whold_wready", WREADY, 0);
      chk("whold_awready", AWREADY, 1);
      chk("whold_bvalid", BVALID, 0);
      tick();
    end
    chk("whold_wready3", WREADY, 0);
    AWADDR = 32'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("whold_bvalid_lat1", BVALID, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bstall_bvalid", BVALID, 1);
      chk("bstall_bresp", BRESP, 0);
      chk("bstall_awready", AWREADY, 0);
      chk("bstall_wready", WREADY, 0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bhs_bvalid", BVALID, 0);
    chk("bhs_awready", AWREADY, 1);
    chk("bhs_wready", WREADY, 1);
    rd(32'h08, d, r);
    chk("whold_rdata", d, 32'h11);

    // AR on the same edge as a commit to the same register
    AWADDR = 32'h0C; WDATA = 32'h55; WSTRB = 4'hF;
    ARADDR = 32'h0C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("sim_rvalid", RVALID, 1);
    chk("sim_rdata_old", RDATA, 32'h0);
    chk("sim_bvalid", BVALID, 1);
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    rd(32'h0C, d, r);
    chk("sim_rdata_new", d, 32'h55);

    // Reset while a write response is pending
    AWADDR = 32'h00; WDATA = 32'hFFFF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("rstb_bvalid_pre", BVALID, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("rstb_bvalid", BVALID, 0);
    chk("rstb_led", led, 0);
    chk("rstb_awready", AWREADY, 1);
    BREADY = 1'b1;
    repeat (2) begin
      tick();
      chk("rstb_no_resp", BVALID, 0);
    end
    BREADY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4), d, r);
      chk($sformatf("rstb_reg%0d", i), d, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
